line_nav_sequencer: RTL and testbench

Parametrised successor to the single-command robot line-follow controller. Accepts direction commands through a valid/ready FIFO and executes them back-to-back with no host intervention. Debounces the three line sensors and uses an internal step timer with turn timeouts and a fault state. Sits between the command decoder (upstream) and the motor PWM / ultrasonic blocks (downstream).

---
 rtl/line_nav_sequencer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_line_nav_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_nav_sequencer.sv
// line_nav_sequencer: queued line-follow / turn / reverse command sequencer.
// Commands arrive through a small FIFO and run back-to-back. The three line
// sensors are synchronised and debounced. One step timer times travel, turn
// phases and reversing, and a stuck turn drops into FAULT until cleared.
module line_nav_sequencer #(
    parameter int DEPTH        = 4,
    parameter int TIMER_W      = 27,
    parameter int DEBOUNCE     = 50000,
    parameter int MIN_TRAVEL   = 25000000,
    parameter int TURN_TIMEOUT = 100000000,
    parameter int BACK_CYCLES  = 50000000,
    parameter int ULTRA_PERIOD = 5000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sensor_l,
    input  logic                       sensor_m,
    input  logic                       sensor_r,
    input  logic [2:0]                 cmd_in,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       clear_fault,
    output logic [2:0]                 output_action,
    output logic                       start_ultrasonic,
    output logic                       cmd_done,
    output logic                       fault,
    output logic [$clog2(DEPTH):0]     queue_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int UL_W  = (ULTRA_PERIOD > 1) ? $clog2(ULTRA_PERIOD) : 1;

    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE - 1);
    localparam logic [UL_W-1:0]    UL_LAST    = UL_W'(ULTRA_PERIOD - 1);
    localparam logic [TIMER_W-1:0] TRAVEL_MIN = TIMER_W'(MIN_TRAVEL);
    localparam logic [TIMER_W-1:0] TURN_LIM   = TIMER_W'(TURN_TIMEOUT);
    localparam logic [TIMER_W-1:0] BACK_LAST  = TIMER_W'(BACK_CYCLES - 1);
    localparam logic [CNT_W-1:0]   FULL_CNT   = CNT_W'(DEPTH);

    // Command codes
    localparam logic [2:0] CMD_FWD   = 3'b001;
    localparam logic [2:0] CMD_RIGHT = 3'b010;
    localparam logic [2:0] CMD_LEFT  = 3'b011;
    localparam logic [2:0] CMD_T180  = 3'b100;
    localparam logic [2:0] CMD_BACK  = 3'b101;

    // Motor actions
    localparam logic [2:0] ACT_STOP    = 3'b000;
    localparam logic [2:0] ACT_FWD     = 3'b001;
    localparam logic [2:0] ACT_GENTL_L = 3'b010;
    localparam logic [2:0] ACT_GENTL_R = 3'b011;
    localparam logic [2:0] ACT_SHARP_L = 3'b100;
    localparam logic [2:0] ACT_SHARP_R = 3'b101;
    localparam logic [2:0] ACT_BACK    = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE, S_FWD, S_FWD_CROSS, S_TURN_LEAVE,
        S_TURN_SEEK, S_BACK, S_DONE, S_FAULT
    } state_t;

    state_t               state_reg, state_next;
    logic [2:0]           cmd_reg, cmd_next;
    logic                 pass_reg, pass_next;
    logic [TIMER_W-1:0]   timer_reg;
    logic [UL_W-1:0]      ultra_reg;
    logic                 pop;

    // ------------------------------------------------------------------
    // Sensor synchroniser and per-bit debounce ({l, m, r})
    // ------------------------------------------------------------------
    logic [2:0] sync1_reg, sync2_reg;
    logic [2:0] filt;

    // Two-flop synchroniser for the asynchronous sensor inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= 3'b000;
            sync2_reg <= 3'b000;
        end else begin
            sync1_reg <= {sensor_l, sensor_m, sensor_r};
            sync2_reg <= sync1_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_debounce
            logic [DB_W-1:0] cnt_reg;
            logic            bit_reg;

            // Flip the filtered bit once the synchronised input has disagreed
            // with it for DEBOUNCE consecutive samples
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg <= '0;
                    bit_reg <= 1'b0;
                end else if (sync2_reg[gi] != bit_reg) begin
                    if (cnt_reg == DB_LAST) begin
                        cnt_reg <= '0;
                        bit_reg <= sync2_reg[gi];
                    end else begin
                        cnt_reg <= cnt_reg + DB_W'(1);
                    end
                end else begin
                    cnt_reg <= '0;
                end
            end

            assign filt[gi] = bit_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Command FIFO (only codes 001..101 are stored)
    // ------------------------------------------------------------------
    logic [2:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             flush;
    logic [2:0]       head;

    assign cmd_ready   = (count_reg != FULL_CNT);
    assign queue_count = count_reg;
    assign push_ok     = cmd_valid && cmd_ready &&
                         (cmd_in >= CMD_FWD) && (cmd_in <= CMD_BACK);
    assign head        = fifo_mem[rd_ptr_reg];
    // The queue is discarded on the cycle the FSM drops into FAULT; a push
    // landing in that same cycle is kept as the first new entry.
    assign flush       = (state_next == S_FAULT) && (state_reg != S_FAULT);

    // Command storage; writes go to slot 0 when the queue is being flushed
    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[flush ? '0 : wr_ptr_reg] <= cmd_in;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= push_ok ? PTR_W'(1) : '0;
            count_reg  <= push_ok ? CNT_W'(1) : '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------

    // State, current command, 180 pass flag, step timer, ultrasonic divider
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cmd_reg   <= 3'b000;
            pass_reg  <= 1'b0;
            timer_reg <= '0;
            ultra_reg <= '0;
        end else begin
            state_reg <= state_next;
            cmd_reg   <= cmd_next;
            pass_reg  <= pass_next;
            if (state_next != state_reg)
                timer_reg <= '0;
            else if (timer_reg != '1)
                timer_reg <= timer_reg + TIMER_W'(1);
            if ((state_next == S_FWD) && (state_reg == S_FWD))
                ultra_reg <= (ultra_reg == UL_LAST) ? '0 : ultra_reg + UL_W'(1);
            else
                ultra_reg <= '0;
        end
    end

    // Next-state and motor action decode
    always_comb begin
        state_next    = state_reg;
        cmd_next      = cmd_reg;
        pass_next     = pass_reg;
        pop           = 1'b0;
        output_action = ACT_STOP;

        case (state_reg)
            S_IDLE: begin
                if (count_reg != '0) begin
                    pop       = 1'b1;
                    cmd_next  = head;
                    pass_next = 1'b0;
                    case (head)
                        CMD_FWD:                        state_next = S_FWD;
                        CMD_RIGHT, CMD_LEFT, CMD_T180:  state_next = S_TURN_LEAVE;
                        CMD_BACK:                       state_next = S_BACK;
                        default:                        state_next = S_IDLE;
                    endcase
                end
            end

            S_FWD: begin
                case (filt)
                    3'b110, 3'b100: output_action = ACT_GENTL_L;
                    3'b011, 3'b001: output_action = ACT_GENTL_R;
                    default:        output_action = ACT_FWD;
                endcase
                if ((filt == 3'b111) && (timer_reg >= TRAVEL_MIN))
                    state_next = S_FWD_CROSS;
            end

            S_FWD_CROSS: begin
                output_action = ACT_FWD;
                if (filt != 3'b111)
                    state_next = S_DONE;
            end

            S_TURN_LEAVE: begin
                output_action = (cmd_reg == CMD_LEFT) ? ACT_SHARP_L : ACT_SHARP_R;
                if (timer_reg == TURN_LIM)
                    state_next = S_FAULT;
                else if (!filt[1])
                    state_next = S_TURN_SEEK;
            end

            S_TURN_SEEK: begin
                output_action = (cmd_reg == CMD_LEFT) ? ACT_SHARP_L : ACT_SHARP_R;
                if (timer_reg == TURN_LIM) begin
                    state_next = S_FAULT;
                end else if (filt[1]) begin
                    if ((cmd_reg == CMD_T180) && !pass_reg) begin
                        pass_next  = 1'b1;
                        state_next = S_TURN_LEAVE;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end

            S_BACK: begin
                output_action = ACT_BACK;
                if (timer_reg == BACK_LAST)
                    state_next = S_DONE;
            end

            S_DONE: begin
                state_next = S_IDLE;
            end

            S_FAULT: begin
                if (clear_fault)
                    state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign cmd_done         = (state_reg == S_DONE);
    assign fault            = (state_reg == S_FAULT);
    assign start_ultrasonic = (state_reg == S_FWD) && (ultra_reg == '0);

endmodule

// File: tb/tb_line_nav_sequencer.sv
// Directed bench for line_nav_sequencer with short timing parameters.
module tb_line_nav_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       sensor_l, sensor_m, sensor_r;
    logic [2:0] cmd_in;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       clear_fault;
    logic [2:0] output_action;
    logic       start_ultrasonic;
    logic       cmd_done;
    logic       fault;
    logic [2:0] queue_count;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    line_nav_sequencer #(
        .DEPTH(4), .TIMER_W(27), .DEBOUNCE(2), .MIN_TRAVEL(8),
        .TURN_TIMEOUT(64), .BACK_CYCLES(10), .ULTRA_PERIOD(16)
    ) dut (
        .clk(clk), .reset(reset),
        .sensor_l(sensor_l), .sensor_m(sensor_m), .sensor_r(sensor_r),
        .cmd_in(cmd_in), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .clear_fault(clear_fault), .output_action(output_action),
        .start_ultrasonic(start_ultrasonic), .cmd_done(cmd_done),
        .fault(fault), .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cmd_done === 1'b1) done_cnt++;

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sens(input logic [2:0] s);
        {sensor_l, sensor_m, sensor_r} = s;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("chk %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic push(input logic [2:0] code);
        cmd_in    = code;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        cmd_in    = 3'b000;
    endtask

    // Starts in the first TURN_LEAVE cycle with filtered m=1; ends in DONE.
    task automatic do_turn(input string tag, input logic [2:0] act, input int passes);
        for (int p = 0; p < passes; p++) begin
            set_sens(3'b000);
            for (int k = 0; k < 6; k++) begin
                step();
                chk({tag, "_leave_act"}, output_action, act);
                chk({tag, "_leave_done"}, cmd_done, 0);
            end
            set_sens(3'b010);
            for (int k = 0; k < 4; k++) begin
                step();
                chk({tag, "_seek_act"}, output_action, act);
            end
            step();
            if (p == passes - 1) begin
                chk({tag, "_done"}, cmd_done, 1);
                chk({tag, "_done_act"}, output_action, 0);
            end else begin
                chk({tag, "_repass_act"}, output_action, act);
                chk({tag, "_repass_done"}, cmd_done, 0);
            end
        end
    endtask

    initial begin
        int got;
        int n;
        int dc;
        logic [2:0] exp_act;

        reset = 1'b1; cmd_in = 3'b000; cmd_valid = 1'b0; clear_fault = 1'b0;
        set_sens(3'b010);
        repeat (3) step();

        // Reset state
        chk("rst_action", output_action, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_count", queue_count, 0);
        chk("rst_fault", fault, 0);
        chk("rst_done", cmd_done, 0);
        chk("rst_ultra", start_ultrasonic, 0);
        reset = 1'b0;
        repeat (8) step();

        // Forward with crossing; FWD entry is i=0
        push(3'b001);
        chk("fwd1_count", queue_count, 1);
        for (int i = 0; i <= 36; i++) begin
            step();
            if (i == 20) set_sens(3'b111);
            if (i == 30) set_sens(3'b010);
            chk("fwd1_act", output_action, (i <= 34) ? 1 : 0);
            chk("fwd1_done", cmd_done, (i == 35) ? 1 : 0);
            chk("fwd1_ultra", start_ultrasonic, (i == 0 || i == 16) ? 1 : 0);
        end
        chk("fwd1_done_cnt", done_cnt, 1);

        // Line-follow corrections, 4-cycle sensor latency
        push(3'b001);
        for (int j = 0; j <= 30; j++) begin
            step();
            if (j == 2)  set_sens(3'b110);
            if (j == 10) set_sens(3'b011);
            if (j == 18) set_sens(3'b111);
            if (j == 24) set_sens(3'b010);
            if (j < 6)       exp_act = 3'b001;
            else if (j < 14) exp_act = 3'b010;
            else if (j < 22) exp_act = 3'b011;
            else if (j < 29) exp_act = 3'b001;
            else             exp_act = 3'b000;
            chk("fwd2_act", output_action, exp_act);
            chk("fwd2_done", cmd_done, (j == 29) ? 1 : 0);
        end

        // Fill the queue while a forward command is running
        push(3'b001);
        step();
        chk("q_fwd_act", output_action, 1);
        push(3'b011);
        push(3'b010);
        push(3'b100);
        push(3'b101);
        chk("q_full_count", queue_count, 4);
        chk("q_full_ready", cmd_ready, 0);
        push(3'b001);
        chk("q_fifth_count", queue_count, 4);
        set_sens(3'b111);
        repeat (6) step();
        set_sens(3'b010);
        got = 0;
        for (int k = 0; k < 20 && got == 0; k++) begin
            step();
            if (cmd_done === 1'b1) got = 1;
        end
        chk("q_fwd_done", got, 1);
        step();
        chk("q_idle_count", queue_count, 4);
        step();
        chk("left_act", output_action, 3'b100);
        chk("left_count", queue_count, 3);
        do_turn("left", 3'b100, 1);
        step(); step();
        chk("right_act", output_action, 3'b101);
        chk("right_count", queue_count, 2);
        do_turn("right", 3'b101, 1);
        step(); step();
        chk("t180_act", output_action, 3'b101);
        do_turn("t180", 3'b101, 2);
        step(); step();
        chk("back_act0", output_action, 3'b110);
        for (int k = 1; k < 10; k++) begin
            step();
            chk("back_act", output_action, 3'b110);
            chk("back_done_early", cmd_done, 0);
        end
        step();
        chk("back_done", cmd_done, 1);
        chk("back_done_act", output_action, 0);
        step();
        chk("q_end_act", output_action, 0);
        chk("q_end_count", queue_count, 0);
        chk("q_done_cnt", done_cnt, 7);

        // Invalid codes are accepted but not stored
        push(3'b000);
        chk("inv0_count", queue_count, 0);
        chk("inv0_ready", cmd_ready, 1);
        push(3'b111);
        chk("inv7_count", queue_count, 0);
        step();
        chk("inv_act", output_action, 0);

        // Turn timeout with m held on the line
        push(3'b011);
        push(3'b001);
        chk("to_count", queue_count, 1);
        chk("to_act", output_action, 3'b100);
        n = 0;
        for (int k = 0; k < 100 && fault !== 1'b1; k++) begin
            if (output_action === 3'b100) n++;
            step();
        end
        chk("to_leave_cycles", n, 65);
        chk("to_fault", fault, 1);
        chk("to_flush_count", queue_count, 0);
        chk("to_fault_act", output_action, 0);
        push(3'b010);
        chk("fault_push_count", queue_count, 1);
        chk("fault_hold", fault, 1);
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;
        chk("clr_fault", fault, 0);
        chk("clr_act", output_action, 0);
        chk("clr_count", queue_count, 1);
        step();
        chk("clr_right_act", output_action, 3'b101);
        push(3'b001);
        chk("pre_rst_count", queue_count, 1);

        // Asynchronous reset mid-turn
        dc = done_cnt;
        reset = 1'b1;
        #1;
        chk("arst_act", output_action, 0);
        chk("arst_count", queue_count, 0);
        chk("arst_ready", cmd_ready, 1);
        chk("arst_fault", fault, 0);
        chk("arst_done", cmd_done, 0);
        repeat (3) step();
        reset = 1'b0;
        repeat (5) step();
        chk("post_rst_act", output_action, 0);
        chk("post_rst_count", queue_count, 0);
        chk("post_rst_no_done", done_cnt, dc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
